// File: rtl/reg_switches.sv
// Switch and push-button input peripheral: 2-FF synchronizers, shared-tick debouncer,
// sticky button-press flags cleared on read, and a registered bus read port.
module reg_switches #(
  parameter int N_SW       = 16,
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 100000,
  parameter int CNT_W      = 17
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic [N_SW-1:0]   sw_i,
  input  logic [N_BTN-1:0]  btn_i,
  input  logic              re_i,
  input  logic              addr_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  output logic              irq_o
);

  localparam int N_IN = N_SW + N_BTN;

  logic [N_IN-1:0]  raw_s;
  logic [N_IN-1:0]  sync1_r;
  logic [N_IN-1:0]  sync2_r;
  logic [N_IN-1:0]  samp_r;
  logic [N_IN-1:0]  deb_r;
  logic [N_IN-1:0]  stable_s;
  logic [N_IN-1:0]  deb_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             tick_s;
  logic [N_SW-1:0]  deb_sw_s;
  logic [N_BTN-1:0] deb_btn_s;
  logic [N_BTN-1:0] deb_btn_q_r;
  logic [N_BTN-1:0] rise_s;
  logic [N_BTN-1:0] pend_r;
  logic [N_BTN-1:0] pend_next_s;
  logic             clr_s;
  logic [31:0]      rdata_s;

  // Switches and buttons share one synchronizer/debounce pipeline; buttons sit in the top bits.
  assign raw_s     = {btn_i, sw_i};
  assign deb_sw_s  = deb_r[N_SW-1:0];
  assign deb_btn_s = deb_r[N_IN-1:N_SW];

  // Tick decode, debounce update, press-event detection and read-data selection.
  always_comb begin
    tick_s     = (cnt_r == CNT_W'(DEB_CYCLES - 1));
    stable_s   = ~(sync2_r ^ samp_r);
    deb_next_s = (deb_r & ~stable_s) | (sync2_r & stable_s);
    rise_s     = deb_btn_s & ~deb_btn_q_r;
    clr_s      = re_i & addr_i;
    // A rising edge in the clearing cycle is OR-ed in after the clear so no event is lost.
    if (clr_s) begin
      pend_next_s = rise_s;
    end else begin
      pend_next_s = pend_r | rise_s;
    end
    rdata_s = 32'd0;
    case (addr_i)
      1'b0:    rdata_s = 32'(deb_sw_s);
      1'b1:    rdata_s = 32'({pend_r, deb_btn_s});
      default: rdata_s = 32'd0;
    endcase
  end

  // Synchronizer chain and free-running debounce tick counter.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      if (tick_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Debounce sample and filtered value, both advancing only on the tick.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      samp_r <= '0;
      deb_r  <= '0;
    end else if (tick_s) begin
      samp_r <= sync2_r;
      deb_r  <= deb_next_s;
    end else begin
      samp_r <= samp_r;
      deb_r  <= deb_r;
    end
  end

  // Button edge history, sticky pending flags and interrupt.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      deb_btn_q_r <= '0;
      pend_r      <= '0;
      irq_o       <= 1'b0;
    end else begin
      deb_btn_q_r <= deb_btn_s;
      pend_r      <= pend_next_s;
      irq_o       <= |pend_r;
    end
  end

  // Bus read port; data_o holds the last read value between reads.
  always_ff @(posedge clk_i) begin
    if (!rst) begin
      data_o  <= 32'd0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= re_i;
      if (re_i) begin
        data_o <= rdata_s;
      end else begin
        data_o <= data_o;
      end
    end
  end

endmodule

// File: tb/tb_reg_switches.sv
// Scoreboard bench for reg_switches with a 4-cycle debounce tick: reads push their
// expected data, a negedge monitor pops and compares on every valid_o pulse.
module tb_reg_switches;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic [3:0]  btn = 4'h0;
  logic        re = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] data;
  logic        valid;
  logic        irq;

  always #5 clk = ~clk;

  reg_switches #(.N_SW(16), .N_BTN(4), .DEB_CYCLES(4), .CNT_W(2)) dut (
    .clk_i  (clk),
    .rst    (rst),
    .sw_i   (sw),
    .btn_i  (btn),
    .re_i   (re),
    .addr_i (addr),
    .data_o (data),
    .valid_o(valid),
    .irq_o  (irq)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
    logic [31:0] alt;
    int          issue;
  } rd_t;

  rd_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  cnt_m = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cycle count and a reference of the debounce tick phase.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) cnt_m <= 0;
    else      cnt_m <= (cnt_m == 3) ? 0 : cnt_m + 1;
  end

  // Scoreboard consumer: each valid_o pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    rd_t it;
    if (valid) begin
      if (sb.size() == 0) begin
        check_value("unexpected_valid", 32'd1, 32'd0);
      end else begin
        it = sb.pop_front();
        check_value({it.tag, "_lat"}, 32'(cyc - it.issue), 32'd1);
        if (it.exp == it.alt)
          check_value(it.tag, data, it.exp);
        else
          check_value(it.tag, {31'd0, (data === it.exp) || (data === it.alt)}, 32'd1);
      end
    end
  end

  task automatic rd(input string tag, input logic a, input logic [31:0] exp, input logic [31:0] alt);
    @(negedge clk);
    re   = 1'b1;
    addr = a;
    sb.push_back('{tag, exp, alt, cyc});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      re = 1'b0;
    end
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 8 && cnt_m != p; i++) @(negedge clk);
  endtask

  initial begin
    // Reset with all switches high
    rst = 1'b0;
    sw  = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_value("rst_data", data, 32'd0);
    check_value("rst_valid", {31'd0, valid}, 32'd0);
    check_value("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    rd("rst_sw", 1'b0, 32'd0, 32'd0);
    idle(1);
    sw = 16'h0000;
    idle(20);
    rd("sw_zero", 1'b0, 32'd0, 32'd0);

    // Switch debounce: polled back-to-back, only 0 or the final value may appear
    idle(1);
    sw = 16'hA5A5;
    for (int k = 1; k <= 14; k++) begin
      if (k >= 11) rd("sw_final", 1'b0, 32'h0000A5A5, 32'h0000A5A5);
      else         rd("sw_poll", 1'b0, 32'h0000A5A5, 32'h00000000);
    end
    idle(2);

    // Two-cycle glitch on btn[0]
    wait_phase(0);
    btn = 4'b0001;
    repeat (2) @(negedge clk);
    btn = 4'b0000;
    idle(16);
    check_value("glitch_irq", {31'd0, irq}, 32'd0);
    rd("glitch_btn", 1'b1, 32'd0, 32'd0);

    // Press and clear
    idle(1);
    btn = 4'b0100;
    idle(16);
    check_value("press_irq", {31'd0, irq}, 32'd1);
    rd("press_rd", 1'b1, 32'h44, 32'h44);
    rd("press_rd2", 1'b1, 32'h04, 32'h04);
    idle(2);
    check_value("clear_irq", {31'd0, irq}, 32'd0);
    check_value("idle_valid", {31'd0, valid}, 32'd0);

    // Debounced btn[1] rise lands in the same cycle as a clearing read
    wait_phase(3);
    btn = 4'b0110;
    repeat (8) @(negedge clk);
    rd("coll_rd", 1'b1, 32'h06, 32'h06);
    rd("coll_rd2", 1'b1, 32'h26, 32'h26);
    idle(1);
    check_value("coll_irq", {31'd0, irq}, 32'd1);
    idle(2);

    // Releases produce no event
    btn = 4'b0000;
    idle(16);
    rd("release_rd", 1'b1, 32'd0, 32'd0);

    // Reset while all four flags are pending
    idle(1);
    btn = 4'hF;
    idle(16);
    check_value("pendf_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_value("midrst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    btn = 4'b0000;
    rd("post_rst", 1'b1, 32'd0, 32'd0);
    idle(16);
    check_value("post_rst_irq", {31'd0, irq}, 32'd0);
    rd("post_rel", 1'b1, 32'd0, 32'd0);
    idle(1);
    btn = 4'b1000;
    idle(16);
    rd("new_press", 1'b1, 32'h88, 32'h88);
    idle(3);

    check_value("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
